// File: rtl/l2_request_arbiter_pkg.sv
// Shared L2 request definitions: payload width and request type encodings.
package l2_request_arbiter_pkg;

  localparam int L2REQ_WIDTH = 600;

  typedef enum logic [2:0] {
    L2REQ_LOAD     = 3'd0,
    L2REQ_STORE    = 3'd1,
    L2REQ_PREFETCH = 3'd2,
    L2REQ_UPGRADE  = 3'd3,
    L2REQ_EVICT    = 3'd4
  } l2req_type_e;

endpackage

// File: rtl/l2_request_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searching upward from the slot after the
// last grant; the pointer only moves when the winner is actually taken.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 update_lru,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_grant,
  output logic [$clog2(N)-1:0] last_grant
);

  typedef logic [$clog2(N)-1:0] idx_t;

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    any_grant = 1'b0;
    idx       = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last_grant) + off) % N;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant_idx  = idx_t'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // Reset points at the top slot so source 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= idx_t'(N - 1);
    end else if (update_lru && any_grant) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Arbitrates L1 miss/store sources onto the registered L2 request port with
// round-robin fairness and per-source outstanding-request credits.
module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES     = 3,
  parameter int REQ_WIDTH       = L2REQ_WIDTH,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_SOURCES-1:0]             src_valid,
  input  logic [NUM_SOURCES*REQ_WIDTH-1:0]   src_packet,
  output logic [NUM_SOURCES-1:0]             src_ack,
  output logic                               l2i_request_valid,
  output logic [REQ_WIDTH-1:0]               l2i_request_packet,
  output logic [$clog2(NUM_SOURCES)-1:0]     l2i_request_source,
  input  logic                               l2_ready,
  input  logic                               rsp_valid,
  input  logic [$clog2(NUM_SOURCES)-1:0]     rsp_source,
  output logic [NUM_SOURCES-1:0]             src_credit_avail
);

  localparam int IW = $clog2(NUM_SOURCES);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IW-1:0] src_idx_t;
  typedef logic [CW-1:0] cnt_t;

  // Handshake: a request moves when the output register is empty or is being
  // drained (l2_ready) this cycle; src_ack marks the source whose packet moved.
  logic                 load;
  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] grant;
  src_idx_t             grant_idx;
  src_idx_t             last_grant;
  logic                 any_grant;
  logic [REQ_WIDTH-1:0] sel_packet;

  assign load     = !l2i_request_valid || l2_ready;
  assign eligible = src_valid & src_credit_avail;
  assign src_ack  = load ? grant : '0;

  rr_arbiter #(.N(NUM_SOURCES)) u_rr (
    .clk        (clk),
    .reset      (reset),
    .req        (eligible),
    .update_lru (load),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant),
    .last_grant (last_grant)
  );

  always_comb begin
    sel_packet = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grant[i]) sel_packet = sel_packet | src_packet[i*REQ_WIDTH +: REQ_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l2i_request_valid  <= 1'b0;
      l2i_request_packet <= '0;
      l2i_request_source <= '0;
    end else if (load) begin
      l2i_request_valid <= any_grant;
      if (any_grant) begin
        l2i_request_packet <= sel_packet;
        l2i_request_source <= grant_idx;
      end
    end
  end

  // One credit counter per source; a response for an idle source is dropped.
  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_credit
    localparam src_idx_t IDX = src_idx_t'(g);
    cnt_t cnt;
    logic inc;
    logic dec;

    assign inc = src_ack[g];
    assign dec = rsp_valid && (rsp_source == IDX) && (cnt != '0);
    assign src_credit_avail[g] = cnt < cnt_t'(MAX_OUTSTANDING);

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
      end else if (inc && !dec) begin
        cnt <= cnt + cnt_t'(1);
      end else if (dec && !inc) begin
        cnt <= cnt - cnt_t'(1);
      end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !(rsp_valid && rsp_source == IDX && cnt == '0));
  end

  a_rsp_source_range: assert property (@(posedge clk) disable iff (reset)
    rsp_valid |-> (int'(rsp_source) < NUM_SOURCES));

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: 3 sources, 16-bit payloads, 2 credits.
module tb_l2_request_arbiter;

  localparam int NS  = 3;
  localparam int W   = 16;
  localparam int MAX = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS-1:0]   src_valid;
  logic [NS*W-1:0] src_packet;
  logic [NS-1:0]   src_ack;
  logic            l2i_request_valid;
  logic [W-1:0]    l2i_request_packet;
  logic [1:0]      l2i_request_source;
  logic            l2_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_source;
  logic [NS-1:0]   src_credit_avail;

  int total = 0;
  int bad   = 0;

  l2_request_arbiter #(.NUM_SOURCES(NS), .REQ_WIDTH(W), .MAX_OUTSTANDING(MAX)) dut (
    .clk                (clk),
    .reset              (reset),
    .src_valid          (src_valid),
    .src_packet         (src_packet),
    .src_ack            (src_ack),
    .l2i_request_valid  (l2i_request_valid),
    .l2i_request_packet (l2i_request_packet),
    .l2i_request_source (l2i_request_source),
    .l2_ready           (l2_ready),
    .rsp_valid          (rsp_valid),
    .rsp_source         (rsp_source),
    .src_credit_avail   (src_credit_avail)
  );

  always #5 clk = ~clk;

  // Clock/reset: leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    reset      = 1'b1;
    src_valid  = '0;
    l2_ready   = 1'b1;
    rsp_valid  = 1'b0;
    rsp_source = '0;
    src_packet = {16'hC002, 16'hB001, 16'hA000};
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (l2i_request_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", l2i_request_valid); end
    total++;
    if (l2i_request_packet !== 16'h0) begin bad++; $display("FAIL reset_packet got=%h exp=0000", l2i_request_packet); end
    total++;
    if (l2i_request_source !== 2'd0) begin bad++; $display("FAIL reset_source got=%0d exp=0", l2i_request_source); end
    total++;
    if (src_ack !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b exp=000", src_ack); end
    total++;
    if (src_credit_avail !== 3'b111) begin bad++; $display("FAIL reset_credit got=%b exp=111", src_credit_avail); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_ack [4];
    logic [1:0]  exp_src [4];
    logic [15:0] exp_pkt [4];
    exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_src = '{2'd0, 2'd1, 2'd2, 2'd0};
    exp_pkt = '{16'hA000, 16'hB001, 16'hC002, 16'hA000};
    do_reset();
    src_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (src_ack !== exp_ack[k]) begin bad++; $display("FAIL rr_ack[%0d] got=%b exp=%b", k, src_ack, exp_ack[k]); end
      step();
      total++;
      if (l2i_request_valid !== 1'b1 || l2i_request_source !== exp_src[k] || l2i_request_packet !== exp_pkt[k]) begin
        bad++;
        $display("FAIL rr_out[%0d] got=%b/%0d/%h exp=1/%0d/%h", k, l2i_request_valid,
                 l2i_request_source, l2i_request_packet, exp_src[k], exp_pkt[k]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    src_valid = 3'b111;
    step();
    l2_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (src_ack !== 3'b000 || l2i_request_valid !== 1'b1 || l2i_request_source !== 2'd0 ||
          l2i_request_packet !== 16'hA000) begin
        bad++;
        $display("FAIL stall[%0d] got ack=%b v=%b src=%0d pkt=%h exp ack=000 v=1 src=0 pkt=a000",
                 k, src_ack, l2i_request_valid, l2i_request_source, l2i_request_packet);
      end
      step();
    end
    l2_ready = 1'b1;
    @(negedge clk);
    total++;
    if (src_ack !== 3'b010) begin bad++; $display("FAIL stall_release_ack got=%b exp=010", src_ack); end
    step();
    total++;
    if (l2i_request_source !== 2'd1 || l2i_request_packet !== 16'hB001) begin
      bad++;
      $display("FAIL stall_release_out got=%0d/%h exp=1/b001", l2i_request_source, l2i_request_packet);
    end
  endtask

  task automatic test_credit_limit();
    do_reset();
    src_valid = 3'b010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (src_ack !== 3'b010) begin bad++; $display("FAIL credit_ack[%0d] got=%b exp=010", k, src_ack); end
      step();
    end
    total++;
    if (src_credit_avail !== 3'b101) begin bad++; $display("FAIL credit_exhausted got=%b exp=101", src_credit_avail); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (src_ack !== 3'b000) begin bad++; $display("FAIL credit_blocked[%0d] got=%b exp=000", k, src_ack); end
      step();
    end
    total++;
    if (l2i_request_valid !== 1'b0) begin bad++; $display("FAIL credit_drain_valid got=%b exp=0", l2i_request_valid); end
    rsp_valid  = 1'b1;
    rsp_source = 2'd1;
    @(negedge clk);
    total++;
    if (src_ack !== 3'b000) begin bad++; $display("FAIL credit_rsp_same_cycle got=%b exp=000", src_ack); end
    step();
    rsp_valid = 1'b0;
    total++;
    if (src_credit_avail !== 3'b111) begin bad++; $display("FAIL credit_returned got=%b exp=111", src_credit_avail); end
    @(negedge clk);
    total++;
    if (src_ack !== 3'b010) begin bad++; $display("FAIL credit_regrant got=%b exp=010", src_ack); end
    step();
    total++;
    if (src_credit_avail !== 3'b101) begin bad++; $display("FAIL credit_reexhaust got=%b exp=101", src_credit_avail); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    src_valid = 3'b001;
    step();
    rsp_valid  = 1'b1;
    rsp_source = 2'd0;
    @(negedge clk);
    total++;
    if (src_ack !== 3'b001) begin bad++; $display("FAIL simul_ack got=%b exp=001", src_ack); end
    step();
    rsp_valid = 1'b0;
    total++;
    if (src_credit_avail[0] !== 1'b1) begin bad++; $display("FAIL simul_hold got=%b exp=1", src_credit_avail[0]); end
    step();
    total++;
    if (src_credit_avail[0] !== 1'b0) begin bad++; $display("FAIL simul_count got=%b exp=0", src_credit_avail[0]); end
    src_valid = 3'b000;
  endtask

  task automatic test_fairness();
    logic [2:0] vec     [9];
    logic [2:0] exp_ack [9];
    logic       have_prev;
    logic [1:0] prev_src;
    int         since_src2;
    vec     = '{3'b111, 3'b110, 3'b101, 3'b111, 3'b111, 3'b101, 3'b111, 3'b110, 3'b110};
    exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    have_prev  = 1'b0;
    prev_src   = '0;
    since_src2 = 0;
    for (int k = 0; k < 9; k++) begin
      src_valid  = vec[k];
      rsp_valid  = have_prev;
      rsp_source = prev_src;
      @(negedge clk);
      total++;
      if (src_ack !== exp_ack[k]) begin bad++; $display("FAIL fair_ack[%0d] got=%b exp=%b", k, src_ack, exp_ack[k]); end
      since_src2 = src_ack[2] ? 0 : since_src2 + 1;
      have_prev = 1'b1;
      prev_src  = (k % 3 == 0) ? 2'd0 : (k % 3 == 1) ? 2'd1 : 2'd2;
      step();
    end
    rsp_valid = 1'b0;
    src_valid = '0;
    total++;
    if (since_src2 > 2) begin bad++; $display("FAIL fair_gap got=%0d exp<=2", since_src2); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    src_valid = 3'b111;
    l2_ready  = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    total++;
    if (l2i_request_valid !== 1'b0 || l2i_request_packet !== 16'h0 || src_credit_avail !== 3'b111) begin
      bad++;
      $display("FAIL midreset got v=%b pkt=%h cred=%b exp v=0 pkt=0000 cred=111",
               l2i_request_valid, l2i_request_packet, src_credit_avail);
    end
    reset    = 1'b0;
    l2_ready = 1'b1;
    @(negedge clk);
    total++;
    if (src_ack !== 3'b001) begin bad++; $display("FAIL midreset_first_grant got=%b exp=001", src_ack); end
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_credit_limit();
    test_simultaneous();
    test_fairness();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
